regfile_sb: RTL

Parametrised dual-bank (integer/FPU) register file with a built-in destination scoreboard. It sits between decode (ID) and write-back (WB) of the core pipeline. It provides NRD combinational read ports with same-cycle write-back bypass and hardwired zero registers. It also tracks outstanding writes per register, so decode can detect RAW hazards and refuse WAW issues.

---
 rtl/regfile_sb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: dual-bank (integer / FPU) register file with a destination
// scoreboard, placed between decode and write-back.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   rs_id, rs_fpu   NRD read addresses (port k at [k*AW +: AW]) and bank selects
//   rs_data         NRD read data words (port k at [k*XLEN +: XLEN])
//   rs_busy         per-port "source has an outstanding write" flag
//   iss_valid, iss_rd, iss_bank, iss_ready
//                   destination issue handshake from decode
//   wb_regwrite, wb_rd, wb_data
//                   write-back port (bank 01 integer, 10 FPU)
//   flush           clears every pending bit
//   pend_cnt        number of pending bits set across both banks
//   dbg_reg         integer register DBG_IDX
module regfile_sb #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int NRD          = 3,
  parameter int INT_ZERO_IDX = 0,
  parameter int FP_ZERO_IDX  = 31,
  parameter int DBG_IDX      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rs_id,
  input  logic [NRD-1:0]       rs_fpu,
  output logic [NRD*XLEN-1:0]  rs_data,
  output logic [NRD-1:0]       rs_busy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [1:0]           iss_bank,
  output logic                 iss_ready,
  input  logic [1:0]           wb_regwrite,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic [AW+1:0]        pend_cnt,
  output logic [XLEN-1:0]      dbg_reg
);

  localparam int              NREG     = 2**AW;
  localparam logic [AW-1:0]   INT_ZERO = AW'(INT_ZERO_IDX);
  localparam logic [AW-1:0]   FP_ZERO  = AW'(FP_ZERO_IDX);
  localparam logic [AW-1:0]   DBG      = AW'(DBG_IDX);
  localparam logic [1:0]      BANK_INT = 2'b01;
  localparam logic [1:0]      BANK_FP  = 2'b10;

  logic [XLEN-1:0] ibank [NREG];
  logic [XLEN-1:0] fbank [NREG];
  logic [NREG-1:0] ipend, fpend;
  logic [NREG-1:0] ipend_nxt, fpend_nxt;

  // Write-back and issue decode; zero registers are never written or tracked.
  logic wb_int, wb_fp;
  logic iss_int, iss_fp, iss_live;
  logic iss_hit_pend, wb_same, iss_set, wb_dec;

  assign wb_int   = (wb_regwrite == BANK_INT) && (wb_rd != INT_ZERO);
  assign wb_fp    = (wb_regwrite == BANK_FP)  && (wb_rd != FP_ZERO);
  assign iss_int  = (iss_bank == BANK_INT) && (iss_rd != INT_ZERO);
  assign iss_fp   = (iss_bank == BANK_FP)  && (iss_rd != FP_ZERO);
  assign iss_live = iss_int | iss_fp;

  // A pending destination may be re-issued in the very cycle its write-back
  // retires it, so the WAW block is lifted when the write-back hits it.
  assign wb_same      = ((iss_int & wb_int) | (iss_fp & wb_fp)) & (iss_rd == wb_rd);
  assign iss_hit_pend = (iss_int & ipend[iss_rd]) | (iss_fp & fpend[iss_rd]);
  assign iss_ready    = !rst && !flush && !(iss_hit_pend && !wb_same);
  assign iss_set      = iss_valid & iss_ready & iss_live;
  assign wb_dec       = (wb_int & ipend[wb_rd]) | (wb_fp & fpend[wb_rd]);

  // Clear on write-back first, then set on issue, so a same-register
  // issue/write-back pair leaves the bit set.
  always_comb begin
    // NOTE: defaulting to the current value makes every path assign the
    // outputs, so no latch is inferred.
    ipend_nxt = ipend;
    fpend_nxt = fpend;
    if (wb_int)            ipend_nxt[wb_rd]  = 1'b0;
    if (wb_fp)             fpend_nxt[wb_rd]  = 1'b0;
    if (iss_set && iss_int) ipend_nxt[iss_rd] = 1'b1;
    if (iss_set && iss_fp)  fpend_nxt[iss_rd] = 1'b1;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the banks are reset explicitly because software relies on all
      // registers reading zero after reset; this keeps them out of RAM macros.
      for (int i = 0; i < NREG; i++) begin
        ibank[i] <= '0;
        fbank[i] <= '0;
      end
      ipend    <= '0;
      fpend    <= '0;
      pend_cnt <= '0;
    end else begin
      if (wb_int) ibank[wb_rd] <= wb_data;
      if (wb_fp)  fbank[wb_rd] <= wb_data;
      if (flush) begin
        ipend    <= '0;
        fpend    <= '0;
        pend_cnt <= '0;
      end else begin
        ipend    <= ipend_nxt;
        fpend    <= fpend_nxt;
        pend_cnt <= pend_cnt + (AW+2)'(iss_set) - (AW+2)'(wb_dec);
      end
    end
  end

  // Read ports: zero register, then write-back bypass, then storage.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_fp, is_zero, bypass;

    assign addr    = rs_id[k*AW +: AW];
    assign is_fp   = rs_fpu[k];
    assign is_zero = is_fp ? (addr == FP_ZERO) : (addr == INT_ZERO);
    assign bypass  = (is_fp ? wb_fp : wb_int) && (wb_rd == addr);

    assign rs_data[k*XLEN +: XLEN] = is_zero ? '0
                                   : bypass  ? wb_data
                                   : is_fp   ? fbank[addr]
                                   :           ibank[addr];
    assign rs_busy[k] = !is_zero && !bypass && (is_fp ? fpend[addr] : ipend[addr]);
  end

  assign dbg_reg = ibank[DBG];

endmodule
